// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with r0 hardwired to zero and a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward the write port onto matching read ports in the same cycle.
module regfile_scoreboard #(
  parameter int N = 8,
  parameter int NREGS = 8,
  localparam int AW = $clog2(NREGS),
  localparam int CW = $clog2(NREGS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  wd3,
  input  logic [AW-1:0] wa3,
  input  logic          we3,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic          rsv_en,
  input  logic [AW-1:0] rsv_a,
  output logic [N-1:0]  rd1,
  output logic [N-1:0]  rd2,
  output logic          busy1,
  output logic          busy2,
  output logic [CW-1:0] pend_cnt,
  output logic          rsv_ok
);
  logic [N-1:0] regs [NREGS];
  logic [NREGS-1:0] busy, busy_nxt;
  logic [CW-1:0] cnt_nxt;
  logic wr;
  assign wr = we3 && (wa3 != '0);
  assign rsv_ok = rsv_en && (rsv_a != '0) && !busy[rsv_a];
  // the reservation is applied after the write so a same-edge set wins over the clear
  always_comb begin
    busy_nxt = busy;
    if (wr) busy_nxt[wa3] = 1'b0;
    if (rsv_ok) busy_nxt[rsv_a] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr) regs[wa3] <= wd3;
      busy <= busy_nxt;
      pend_cnt <= cnt_nxt;
    end
  end
`ifdef REGFILE_BYPASS_EN
  logic fwd1, fwd2;
  assign fwd1 = wr && (wa3 == ra1);
  assign fwd2 = wr && (wa3 == ra2);
  assign rd1 = fwd1 ? wd3 : regs[ra1];
  assign rd2 = fwd2 ? wd3 : regs[ra2];
  assign busy1 = fwd1 ? 1'b0 : busy[ra1];
  assign busy2 = fwd2 ? 1'b0 : busy[ra2];
`else
  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];
  assign busy1 = busy[ra1];
  assign busy2 = busy[ra2];
`endif
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed checks of reads, writes, reservations and collisions.
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] wd3 = '0;
  logic [2:0] wa3 = '0, ra1 = '0, ra2 = '0, rsv_a = '0;
  logic we3 = 1'b0, rsv_en = 1'b0;
  logic [7:0] rd1, rd2;
  logic busy1, busy2, rsv_ok;
  logic [3:0] pend_cnt;
  int n_cmp = 0, n_err = 0;

  regfile_scoreboard #(.N(8), .NREGS(8)) dut (
    .clk(clk), .rst(rst), .wd3(wd3), .wa3(wa3), .we3(we3), .ra1(ra1), .ra2(ra2),
    .rsv_en(rsv_en), .rsv_a(rsv_a), .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2),
    .pend_cnt(pend_cnt), .rsv_ok(rsv_ok)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (rd1 !== 8'h00) begin n_err++; $display("FAIL reset0_rd1 got=%h exp=00", rd1); end
    n_cmp++; if (pend_cnt !== 4'd0) begin n_err++; $display("FAIL reset0_pend got=%0d exp=0", pend_cnt); end
    n_cmp++; if ({busy1, busy2, rsv_ok} !== 3'b000) begin n_err++; $display("FAIL reset0_flags got=%b exp=000", {busy1, busy2, rsv_ok}); end
    rst = 1'b1;
    step();
    we3 = 1'b1; wa3 = 3'd3; wd3 = 8'hAB; rsv_en = 1'b1; rsv_a = 3'd4;
    step();
    we3 = 1'b0; rsv_en = 1'b0; ra1 = 3'd3;
    #1;
    n_cmp++; if (rd1 !== 8'hAB) begin n_err++; $display("FAIL reset_pre_rd1 got=%h exp=ab", rd1); end
    n_cmp++; if (pend_cnt !== 4'd1) begin n_err++; $display("FAIL reset_pre_pend got=%0d exp=1", pend_cnt); end
    rst = 1'b0;
    #1;
    n_cmp++; if (rd1 !== 8'h00) begin n_err++; $display("FAIL reset_mid_rd1 got=%h exp=00", rd1); end
    n_cmp++; if (pend_cnt !== 4'd0) begin n_err++; $display("FAIL reset_mid_pend got=%0d exp=0", pend_cnt); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    we3 = 1'b1; wa3 = 3'd1; wd3 = 8'hAB;
    step();
    wa3 = 3'd4; wd3 = 8'hFF;
    step();
    we3 = 1'b0; ra1 = 3'd1; ra2 = 3'd4;
    #1;
    n_cmp++; if (rd1 !== 8'hAB) begin n_err++; $display("FAIL wr_rd1 got=%h exp=ab", rd1); end
    n_cmp++; if (rd2 !== 8'hFF) begin n_err++; $display("FAIL wr_rd2 got=%h exp=ff", rd2); end
    ra2 = 3'd1;
    #1;
    n_cmp++; if (rd2 !== 8'hAB) begin n_err++; $display("FAIL wr_same_rd2 got=%h exp=ab", rd2); end
    we3 = 1'b1; wa3 = 3'd0; wd3 = 8'h55;
    step();
    we3 = 1'b0; ra1 = 3'd0;
    #1;
    n_cmp++; if (rd1 !== 8'h00) begin n_err++; $display("FAIL wr_r0 got=%h exp=00", rd1); end
  endtask

  task automatic test_scoreboard();
    rsv_en = 1'b1; rsv_a = 3'd5;
    #1;
    n_cmp++; if (rsv_ok !== 1'b1) begin n_err++; $display("FAIL sb_rsv_ok got=%b exp=1", rsv_ok); end
    step();
    ra1 = 3'd5;
    #1;
    n_cmp++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL sb_busy1 got=%b exp=1", busy1); end
    n_cmp++; if (pend_cnt !== 4'd1) begin n_err++; $display("FAIL sb_pend1 got=%0d exp=1", pend_cnt); end
    n_cmp++; if (rsv_ok !== 1'b0) begin n_err++; $display("FAIL sb_rereserve got=%b exp=0", rsv_ok); end
    step();
    rsv_en = 1'b0;
    n_cmp++; if (pend_cnt !== 4'd1) begin n_err++; $display("FAIL sb_pend_hold got=%0d exp=1", pend_cnt); end
    we3 = 1'b1; wa3 = 3'd5; wd3 = 8'hAF;
    step();
    we3 = 1'b0;
    #1;
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL sb_busy_clr got=%b exp=0", busy1); end
    n_cmp++; if (pend_cnt !== 4'd0) begin n_err++; $display("FAIL sb_pend0 got=%0d exp=0", pend_cnt); end
    n_cmp++; if (rd1 !== 8'hAF) begin n_err++; $display("FAIL sb_rd1 got=%h exp=af", rd1); end
  endtask

  task automatic test_collision();
    ra2 = 3'd0;
    rsv_en = 1'b1; rsv_a = 3'd2;
    step();
    we3 = 1'b1; wa3 = 3'd2; wd3 = 8'h11;
    #1;
    n_cmp++; if (rsv_ok !== 1'b0) begin n_err++; $display("FAIL col_busy_rsv_ok got=%b exp=0", rsv_ok); end
    step();
    we3 = 1'b0; rsv_en = 1'b0; ra2 = 3'd2;
    #1;
    n_cmp++; if (rd2 !== 8'h11) begin n_err++; $display("FAIL col_busy_rd2 got=%h exp=11", rd2); end
    n_cmp++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL col_busy_busy2 got=%b exp=0", busy2); end
    n_cmp++; if (pend_cnt !== 4'd0) begin n_err++; $display("FAIL col_busy_pend got=%0d exp=0", pend_cnt); end
    ra2 = 3'd0;
    we3 = 1'b1; wa3 = 3'd2; wd3 = 8'h22; rsv_en = 1'b1; rsv_a = 3'd2;
    #1;
    n_cmp++; if (rsv_ok !== 1'b1) begin n_err++; $display("FAIL col_idle_rsv_ok got=%b exp=1", rsv_ok); end
    step();
    we3 = 1'b0; rsv_en = 1'b0; ra2 = 3'd2;
    #1;
    n_cmp++; if (rd2 !== 8'h22) begin n_err++; $display("FAIL col_idle_rd2 got=%h exp=22", rd2); end
    n_cmp++; if (busy2 !== 1'b1) begin n_err++; $display("FAIL col_idle_busy2 got=%b exp=1", busy2); end
    n_cmp++; if (pend_cnt !== 4'd1) begin n_err++; $display("FAIL col_idle_pend got=%0d exp=1", pend_cnt); end
    ra2 = 3'd0; we3 = 1'b1; wa3 = 3'd2; wd3 = 8'h23;
    step();
    we3 = 1'b0;
    n_cmp++; if (pend_cnt !== 4'd0) begin n_err++; $display("FAIL col_release_pend got=%0d exp=0", pend_cnt); end
  endtask

  task automatic test_fill();
    for (int i = 1; i < 8; i++) begin
      rsv_en = 1'b1; rsv_a = 3'(i);
      #1;
      n_cmp++; if (rsv_ok !== 1'b1) begin n_err++; $display("FAIL fill_rsv_ok r%0d got=%b exp=1", i, rsv_ok); end
      step();
      n_cmp++; if (pend_cnt !== 4'(i)) begin n_err++; $display("FAIL fill_pend r%0d got=%0d exp=%0d", i, pend_cnt, i); end
    end
    rsv_a = 3'd0;
    #1;
    n_cmp++; if (rsv_ok !== 1'b0) begin n_err++; $display("FAIL fill_rsv_r0 got=%b exp=0", rsv_ok); end
    step();
    rsv_en = 1'b0;
    n_cmp++; if (pend_cnt !== 4'd7) begin n_err++; $display("FAIL fill_pend_r0 got=%0d exp=7", pend_cnt); end
    for (int i = 1; i < 8; i++) begin
      we3 = 1'b1; wa3 = 3'(i); wd3 = 8'(i << 4);
      step();
      n_cmp++; if (pend_cnt !== 4'(7 - i)) begin n_err++; $display("FAIL drain_pend r%0d got=%0d exp=%0d", i, pend_cnt, 7 - i); end
    end
    we3 = 1'b0; ra1 = 3'd7;
    #1;
    n_cmp++; if (rd1 !== 8'h70) begin n_err++; $display("FAIL drain_rd1 got=%h exp=70", rd1); end
  endtask

  task automatic test_bypass();
    rsv_en = 1'b1; rsv_a = 3'd6;
    step();
    rsv_en = 1'b0;
    we3 = 1'b1; wa3 = 3'd6; wd3 = 8'h3C; ra1 = 3'd6;
    #1;
`ifdef REGFILE_BYPASS_EN
    n_cmp++; if (rd1 !== 8'h3C) begin n_err++; $display("FAIL byp_rd1 got=%h exp=3c", rd1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL byp_busy1 got=%b exp=0", busy1); end
`else
    n_cmp++; if (rd1 !== 8'h60) begin n_err++; $display("FAIL nobyp_rd1 got=%h exp=60", rd1); end
    n_cmp++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL nobyp_busy1 got=%b exp=1", busy1); end
`endif
    step();
    we3 = 1'b0;
    #1;
    n_cmp++; if (rd1 !== 8'h3C) begin n_err++; $display("FAIL byp_after_rd1 got=%h exp=3c", rd1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL byp_after_busy1 got=%b exp=0", busy1); end
    n_cmp++; if (pend_cnt !== 4'd0) begin n_err++; $display("FAIL byp_after_pend got=%0d exp=0", pend_cnt); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_collision();
    test_fill();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised register file for the datapath.
- Provides 2 asynchronous read ports, 1 synchronous write port, and register 0 hardwired to zero.
- Adds a per-register busy scoreboard so the control unit can reserve a destination for a multi-cycle result and stall dependent reads until the write-back arrives.
- Sits between decode (ra1/ra2, reservations) and write-back (wa3/wd3/we3).

Parameters:
N, 8, data width in bits
NREGS, 8, number of registers (power of 2, >= 2)
AW, $clog2(NREGS), address width (localparam, not overridable)
CW, $clog2(NREGS+1), pend_cnt width (localparam)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
wd3  in  N  write data
wa3  in  AW  write address
we3  in  1  write enable
ra1  in  AW  read address, port 1
ra2  in  AW  read address, port 2
rsv_en  in  1  reserve request: mark rsv_a busy
rsv_a  in  AW  register to reserve
rd1  out  N  read data, port 1
rd2  out  N  read data, port 2
busy1  out  1  register ra1 has a pending result
busy2  out  1  register ra2 has a pending result
pend_cnt  out  CW  number of registers currently busy
rsv_ok  out  1  rsv_en accepted this cycle

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - all registers = 0; all busy bits = 0.
  - Hence rd1=rd2=0, busy1=busy2=0, pend_cnt=0, rsv_ok=0.
  - Reset held low overrides any write or reservation.
  - Deassertion takes effect at the first rising clk after rst=1.
- Register 0:
  - always reads 0.
  - Writes to address 0 are ignored.
  - Reservations of address 0 are ignored: rsv_ok=0, pend_cnt unchanged.
- Write:
  - at posedge clk with we3=1 and wa3!=0: reg[wa3] <= wd3 and busy[wa3] <= 0.
  - Data is visible on a matching read port in the cycle after the edge (unless the bypass feature is on).
- Reads:
  - combinational. rd1=reg[ra1], rd2=reg[ra2].
  - busy1=busy[ra1], busy2=busy[ra2].
  - Both ports may address the same register.
- Reservation:
  - rsv_ok = rsv_en & (rsv_a!=0) & ~busy[rsv_a], combinational.
  - At posedge with rsv_ok=1: busy[rsv_a] <= 1.
  - Reserving an already-busy register is rejected (rsv_ok=0) with no state change; the control unit must stall.
- Simultaneous write and reservation, same address, same edge:
  - data is written.
  - busy ends at 1: the set wins, because the new producer owns the register.
  - rsv_ok is evaluated on the pre-edge busy value, so a register that is busy and being written this cycle is still rejected.
- Simultaneous write and reservation, different addresses: both take effect independently.
- pend_cnt:
  - registered popcount of the busy bits, updated on the same edge as they are.
  - Range 0..NREGS-1, never wraps.
  - Net change per edge: +1 (reservation only), -1 (a write clears a busy bit, no reservation), or 0.
- A write to a non-busy register is legal: data updates and busy stays 0.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-through forwarding.
  - If we3=1, wa3!=0 and wa3==ra1, then rd1=wd3 and busy1=0 in the same cycle. Same rule for port 2.
  - busy2/rd2 follow the same rule on ra2.
  - Storage timing is unchanged.
- Undefined: reads return stored contents only, and busy reflects the stored bit. A dependent read waits one extra cycle after write-back.

Test Plan:
- Reset: write 8'hAB to r3, then pulse rst=0 mid-cycle (between edges) -> rd1(ra1=3)=0 and pend_cnt=0 immediately, with no clock edge.
- Write/read: we3=1, wa3=1, wd3=8'hAB, then wa3=4, wd3=8'hFF, then ra1=1, ra2=4 -> rd1=8'hAB, rd2=8'hFF. Separately, write 8'h55 to r0 -> rd1(ra1=0)=0.
- Scoreboard: rsv_en=1, rsv_a=5 -> rsv_ok=1; next cycle busy1(ra1=5)=1, pend_cnt=1. A second reserve of r5 -> rsv_ok=0, pend_cnt=1. Write 8'hAF to r5 -> busy1=0, pend_cnt=0, rd1=8'hAF.
- Collision: r2 busy; same edge has we3 to r2 (8'h11) and rsv_en to r2 -> rsv_ok=0, and after the edge rd=8'h11, busy=0. Then, with r2 idle, the same-edge write 8'h22 plus reserve of r2 -> rd=8'h22, busy=1, pend_cnt +1.
- Fill: reserve r1..r7 on consecutive cycles -> pend_cnt reaches 7. Reserving r0 -> rsv_ok=0. Writing r1..r7 back -> pend_cnt counts down to 0.
- Bypass (REGFILE_BYPASS_EN): r6 busy; we3=1, wa3=6, wd3=8'h3C with ra1=6 -> rd1=8'h3C and busy1=0 in the same cycle. Without the macro, rd1 holds its old value and busy1=1 until after the edge.
